prog_mem_responder: RTL and testbench

- Memory-side responder for the CPU's halfword memory interface: synchronous RAM with per-byte write enables and a registered 1-cycle read.
- Also contains a program loader. A host streams a halfword image in over a valid/ready port while the block holds the CPU in reset.
- After the last beat, the block waits a fixed number of cycles, then releases the CPU.
- Sits at top level, between the CPU memory port, an external loader (debug or boot source) and the CPU reset input.

---
 rtl/prog_mem_pkg.sv | 14 +
 rtl/prog_mem_responder_ram_bank.sv | 43 ++++
 rtl/prog_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_prog_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types for the program-memory responder: loader state and halfword layout.
package prog_mem_pkg;

  // Loader sequencing: stream image in, hold the CPU in reset, then let it run.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } ld_state_t;

  // Halfword as two byte lanes; lane 0 is the upper byte.
  typedef logic [0:1][7:0] halfword_t;

endpackage

// File: rtl/prog_mem_responder_ram_bank.sv
// Single-port halfword RAM with per-lane write enables and a registered,
// read-first output. The array has no reset so it can map onto block RAM.
module ram_bank
  import prog_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr,
  input  logic             rd_en,
  input  logic [0:1]       wr_en,
  input  halfword_t        din,
  output halfword_t        dout
);

  halfword_t mem_r [DEPTH];
  halfword_t dout_r;

  // Byte-lane writes into the storage array (contents survive reset).
  always_ff @(posedge clk) begin
    if (wr_en[0]) begin
      mem_r[addr][0] <= din[0];
    end
    if (wr_en[1]) begin
      mem_r[addr][1] <= din[1];
    end
  end

  // Output register samples the array before this edge's write lands, so a
  // same-address read and write returns the old word; it holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r <= {2{8'h00}};
    end else if (rd_en) begin
      dout_r <= mem_r[addr];
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/prog_mem_responder.sv
// Program-memory responder: halfword RAM shared between a streaming program
// loader and the CPU, plus the sequencer that holds the CPU in reset until
// the image is in and a fixed settle delay has elapsed.
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int RST_HOLD  = 4,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [0:1][7:0]       i_mem_di,
  input  logic                  i_mem_en,
  input  logic                  i_mem_rd_en,
  input  logic [0:1]            i_mem_wr_en,
  output logic [0:1][7:0]       o_mem_do,
  input  logic                  i_ld_valid,
  input  logic [15:0]           i_ld_data,
  input  logic                  i_ld_last,
  output logic                  o_ld_ready,
  input  logic                  i_ld_start,
  output logic [ADDR_WIDTH-1:0] o_ld_count,
  output logic                  o_ld_err,
  output logic                  o_cpu_rst
);

  localparam int IDX_W  = ADDR_WIDTH - 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_WIDTH-1:0] COUNT_FULL = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

  ld_state_t             state_r;
  logic [ADDR_WIDTH-1:0] ld_count_r;
  logic                  ld_err_r;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic                  cpu_rst_r;
  logic                  ld_ready_r;

  logic                  room_s;
  logic [IDX_W-1:0]      ram_addr_s;
  logic                  ram_rd_s;
  logic [0:1]            ram_we_s;
  halfword_t             ram_din_s;
  halfword_t             ram_dout_s;
  logic                  addr_lsb_unused_s;

  // The CPU is halfword aligned, so the byte-select bit carries no information.
  assign addr_lsb_unused_s = i_mem_addr[0];

  // Once the count reaches the RAM depth further beats are dropped, not wrapped.
  assign room_s = (ld_count_r != COUNT_FULL);

  // Steer the single RAM port: loader owns it in LOAD, the CPU in RUN, nobody in HOLD.
  always_comb begin
    ram_addr_s = {IDX_W{1'b0}};
    ram_rd_s   = 1'b0;
    ram_we_s   = 2'b00;
    ram_din_s  = i_mem_di;
    case (state_r)
      LOAD: begin
        ram_addr_s = ld_count_r[IDX_W-1:0];
        ram_din_s  = i_ld_data;
        if (i_ld_valid && room_s) begin
          ram_we_s = 2'b11;
        end else begin
          ram_we_s = 2'b00;
        end
      end
      RUN: begin
        ram_addr_s = i_mem_addr[ADDR_WIDTH-1:1];
        if (i_mem_en) begin
          ram_rd_s = i_mem_rd_en;
          ram_we_s = i_mem_wr_en;
        end else begin
          ram_rd_s = 1'b0;
          ram_we_s = 2'b00;
        end
      end
      HOLD: begin
        ram_rd_s = 1'b0;
        ram_we_s = 2'b00;
      end
      default: begin
        ram_rd_s = 1'b0;
        ram_we_s = 2'b00;
      end
    endcase
  end

  // Load/hold/run sequencing with registered loader status and CPU reset.
  // CPU reset drops one edge after RUN is entered, which places the release
  // RST_HOLD+1 edges after the edge that accepted the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= LOAD;
      ld_count_r <= {ADDR_WIDTH{1'b0}};
      ld_err_r   <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      cpu_rst_r  <= 1'b1;
      ld_ready_r <= 1'b1;
    end else begin
      case (state_r)
        LOAD: begin
          if (i_ld_valid) begin
            if (room_s) begin
              ld_count_r <= ld_count_r + ADDR_WIDTH'(1);
            end else begin
              ld_err_r <= 1'b1;
            end
            if (i_ld_last) begin
              state_r    <= HOLD;
              hold_cnt_r <= {HOLD_W{1'b0}};
              ld_ready_r <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r <= RUN;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        RUN: begin
          if (i_ld_start) begin
            state_r    <= LOAD;
            ld_count_r <= {ADDR_WIDTH{1'b0}};
            ld_err_r   <= 1'b0;
            cpu_rst_r  <= 1'b1;
            ld_ready_r <= 1'b1;
          end else begin
            cpu_rst_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= LOAD;
          ld_count_r <= {ADDR_WIDTH{1'b0}};
          ld_err_r   <= 1'b0;
          hold_cnt_r <= {HOLD_W{1'b0}};
          cpu_rst_r  <= 1'b1;
          ld_ready_r <= 1'b1;
        end
      endcase
    end
  end

  ram_bank #(
    .DEPTH (MEM_DEPTH)
  ) u_ram_bank (
    .clk   (clk),
    .rst   (rst),
    .addr  (ram_addr_s),
    .rd_en (ram_rd_s),
    .wr_en (ram_we_s),
    .din   (ram_din_s),
    .dout  (ram_dout_s)
  );

  assign o_mem_do   = ram_dout_s;
  assign o_ld_ready = ld_ready_r;
  assign o_ld_count = ld_count_r;
  assign o_ld_err   = ld_err_r;
  assign o_cpu_rst  = cpu_rst_r;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder: drivers compute expected outputs
// from a word-array model and queue them with a due cycle; a negedge monitor
// compares whatever is due.
module tb_prog_mem_responder;

  localparam int DEPTH    = 4;
  localparam int RST_HOLD = 4;
  localparam int AW       = $clog2(DEPTH * 2);

  localparam int SEL_DO  = 0;
  localparam int SEL_RST = 1;
  localparam int SEL_RDY = 2;
  localparam int SEL_CNT = 3;
  localparam int SEL_ERR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   mem_addr;
  logic [0:1][7:0] mem_di;
  logic            mem_en;
  logic            mem_rd_en;
  logic [0:1]      mem_wr_en;
  logic [0:1][7:0] mem_do;
  logic            ld_valid;
  logic [15:0]     ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_start;
  logic [AW-1:0]   ld_count;
  logic            ld_err;
  logic            cpu_rst;

  prog_mem_responder #(
    .MEM_DEPTH (DEPTH),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_mem_addr  (mem_addr),
    .i_mem_di    (mem_di),
    .i_mem_en    (mem_en),
    .i_mem_rd_en (mem_rd_en),
    .i_mem_wr_en (mem_wr_en),
    .o_mem_do    (mem_do),
    .i_ld_valid  (ld_valid),
    .i_ld_data   (ld_data),
    .i_ld_last   (ld_last),
    .o_ld_ready  (ld_ready),
    .i_ld_start  (ld_start),
    .o_ld_count  (ld_count),
    .o_ld_err    (ld_err),
    .o_cpu_rst   (cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t        sb_q[$];
  logic [15:0] img_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  // Reference model: word array, last read word, loader counters.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_do;
  int          m_count;
  bit          m_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      SEL_DO:  return mem_do;
      SEL_RST: return 16'(cpu_rst);
      SEL_RDY: return 16'(ld_ready);
      SEL_CNT: return 16'(ld_count);
      SEL_ERR: return 16'(ld_err);
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic check_item(input chk_t c, input bit stale);
    logic [15:0] act;
    act = dut_val(c.sel);
    n_total++;
    if (!stale && act === c.exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %h, expected %h%s", c.name, cyc, act, c.exp,
               stale ? " (not checked on time)" : "");
    end
  endtask

  // Monitor: compare every scoreboard entry that falls due on this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due <= cyc) begin
        check_item(sb_q[i], sb_q[i].due < cyc);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_v(input int due, input int sel, input logic [15:0] v, input string nm);
    chk_t c;
    c.due = due; c.sel = sel; c.exp = v; c.name = nm;
    sb_q.push_back(c);
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 2'b00;
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
  endtask

  task automatic load_beat(input logic [15:0] d, input bit last, input string nm);
    @(negedge clk); #1;
    idle_inputs();
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    // A CPU access alongside a beat must be ignored while loading.
    mem_en = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 2'b11;
    mem_addr = AW'($urandom_range(0, 2 * DEPTH - 1)); mem_di = 16'($urandom);
    if (m_count < DEPTH) begin
      m_mem[m_count] = d;
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    expect_v(cyc + 1, SEL_CNT, 16'(m_count), {nm, "_count"});
    expect_v(cyc + 1, SEL_ERR, 16'(m_err), {nm, "_err"});
    expect_v(cyc + 1, SEL_RDY, last ? 16'd0 : 16'd1, {nm, "_ready"});
    expect_v(cyc + 1, SEL_DO, m_do, {nm, "_do_hold"});
    expect_v(cyc + 1, SEL_RST, 16'd1, {nm, "_cpu_rst"});
    if (last) begin
      expect_v(cyc + RST_HOLD + 1, SEL_RST, 16'd1, {nm, "_rst_still_high"});
      expect_v(cyc + RST_HOLD + 2, SEL_RST, 16'd0, {nm, "_rst_release"});
    end
  endtask

  task automatic gap_cycle(input string nm);
    @(negedge clk); #1;
    idle_inputs();
    expect_v(cyc + 1, SEL_CNT, 16'(m_count), {nm, "_gap_count"});
    expect_v(cyc + 1, SEL_RDY, 16'd1, {nm, "_gap_ready"});
  endtask

  task automatic load_image(input bit wait_run, input string nm);
    for (int i = 0; i < img_q.size(); i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) gap_cycle(nm);
      load_beat(img_q[i], i == img_q.size() - 1, nm);
    end
    if (wait_run) begin
      for (int k = 0; k < RST_HOLD + 2; k++) begin
        @(negedge clk); #1;
        idle_inputs();
        ld_start = (k == 1);
        ld_valid = (k == 2);
        ld_data  = 16'($urandom);
        expect_v(cyc + 1, SEL_CNT, 16'(m_count), {nm, "_hold_count"});
        expect_v(cyc + 1, SEL_RDY, 16'd0, {nm, "_hold_ready"});
      end
    end
  endtask

  task automatic cpu_op(input logic [AW-1:0] a, input bit en, input bit rd,
                        input logic [0:1] we, input logic [15:0] d, input string nm);
    int idx;
    @(negedge clk); #1;
    idle_inputs();
    mem_addr = a; mem_en = en; mem_rd_en = rd; mem_wr_en = we; mem_di = d;
    // Loader beats offered while running must not be taken.
    ld_valid = 1'($urandom_range(0, 1)); ld_data = 16'($urandom);
    idx = int'(a) / 2;
    if (en && rd) m_do = m_mem[idx];
    if (en && we[0]) m_mem[idx][15:8] = d[15:8];
    if (en && we[1]) m_mem[idx][7:0] = d[7:0];
    expect_v(cyc + 1, SEL_DO, m_do, nm);
    expect_v(cyc + 1, SEL_CNT, 16'(m_count), {nm, "_count"});
    expect_v(cyc + 1, SEL_RST, 16'd0, {nm, "_cpu_rst"});
  endtask

  task automatic reload(input logic [AW-1:0] a, input logic [15:0] d, input string nm);
    @(negedge clk); #1;
    idle_inputs();
    ld_start = 1'b1;
    mem_en = 1'b1; mem_wr_en = 2'b11; mem_addr = a; mem_di = d;
    m_mem[int'(a) / 2] = d;
    m_count = 0; m_err = 1'b0;
    expect_v(cyc + 1, SEL_RST, 16'd1, {nm, "_cpu_rst"});
    expect_v(cyc + 1, SEL_RDY, 16'd1, {nm, "_ready"});
    expect_v(cyc + 1, SEL_CNT, 16'd0, {nm, "_count"});
    expect_v(cyc + 1, SEL_ERR, 16'd0, {nm, "_err"});
    expect_v(cyc + 1, SEL_DO, m_do, {nm, "_do"});
  endtask

  task automatic expect_reset_now(input string nm);
    m_do = 16'h0000; m_count = 0; m_err = 1'b0;
    expect_v(cyc, SEL_RST, 16'd1, {nm, "_cpu_rst"});
    expect_v(cyc, SEL_RDY, 16'd1, {nm, "_ready"});
    expect_v(cyc, SEL_CNT, 16'd0, {nm, "_count"});
    expect_v(cyc, SEL_ERR, 16'd0, {nm, "_err"});
    expect_v(cyc, SEL_DO, 16'h0000, {nm, "_do"});
  endtask

  task automatic async_reset_mid_hold(input string nm);
    int i;
    @(negedge clk); #1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    // Timing expectations from the interrupted load no longer apply.
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due >= cyc) sb_q.delete(i);
      else i++;
    end
    expect_reset_now(nm);
    @(negedge clk); #3;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    mem_addr = '0; mem_di = 16'h0000; ld_data = 16'h0000;
    m_do = 16'h0000; m_count = 0; m_err = 1'b0;

    @(posedge clk); #2;
    expect_reset_now("reset");
    @(negedge clk); #3;
    rst = 1'b1;

    img_q = {16'h1111, 16'h2222, 16'h3333};
    load_image(1'b1, "load3");

    cpu_op(3'd2, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_a2");
    cpu_op(3'd3, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_a3_lsb");
    cpu_op(3'd4, 1'b1, 1'b0, 2'b10, 16'hABCD, "wr_upper");
    cpu_op(3'd4, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_upper");
    cpu_op(3'd4, 1'b1, 1'b1, 2'b01, 16'hABCD, "rd_wr_same");
    cpu_op(3'd4, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_after");
    cpu_op(3'd0, 1'b0, 1'b1, 2'b11, 16'hDEAD, "en_off");
    cpu_op(3'd0, 1'b1, 1'b0, 2'b00, 16'hBEEF, "wr_none");
    cpu_op(3'd0, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_a0");
    cpu_op(3'd6, 1'b1, 1'b0, 2'b11, 16'h4444, "wr_a6");
    cpu_op(3'd7, 1'b1, 1'b1, 2'b00, 16'h0000, "rd_a7");

    reload(3'd2, 16'h5A5A, "reload_ovf");
    img_q = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    load_image(1'b1, "load_ovf");
    cpu_op(3'd0, 1'b1, 1'b1, 2'b00, 16'h0000, "ovf_rd0");
    cpu_op(3'd6, 1'b1, 1'b1, 2'b00, 16'h0000, "ovf_rd3");

    reload(3'd5, 16'h0F0F, "reload_rst");
    img_q = {16'($urandom), 16'($urandom)};
    load_image(1'b0, "load_cut");
    async_reset_mid_hold("async_rst");
    img_q = {16'hC0DE};
    load_image(1'b1, "load_empty");
    cpu_op(3'd0, 1'b1, 1'b1, 2'b00, 16'h0000, "keep_rd0");
    cpu_op(3'd2, 1'b1, 1'b1, 2'b00, 16'h0000, "keep_rd1");
    cpu_op(3'd6, 1'b1, 1'b1, 2'b00, 16'h0000, "keep_rd3");

    for (int it = 0; it < 4; it++) begin
      reload(AW'($urandom_range(0, 2 * DEPTH - 1)), 16'($urandom), "rnd_reload");
      img_q.delete();
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) img_q.push_back(16'($urandom));
      load_image(1'b1, "rnd_load");
      for (int n = 0; n < 25; n++) begin
        cpu_op(AW'($urandom_range(0, 2 * DEPTH - 1)), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), "rnd_op");
      end
    end

    @(negedge clk); #1;
    idle_inputs();
    repeat (RST_HOLD + 4) @(negedge clk);
    #1;
    foreach (sb_q[i]) begin
      n_total++;
      $display("FAIL %s never checked: due cycle %0d, expected %h", sb_q[i].name, sb_q[i].due, sb_q[i].exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
